// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and helpers for the iterative divide/writeback unit
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [31:0] XLEN_MIN_NEG = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        WB   = 2'd3
    } div_state_t;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring shift-subtract divider datapath, one bit per step
module div_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The extra top bit carries the shifted-out remainder MSB so the compare
    // stays correct when the partial remainder exceeds 2^(XLEN-1).
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_wb_unit.sv
// rtl/div_wb_unit.sv - RV32M DIV/DIVU/REM/REMU unit driving a one-cycle register-file write
module div_wb_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            wb_we,
    output logic [4:0]      wb_wa,
    output logic [XLEN-1:0] wb_wd
);
    import div_pkg::*;

    localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

    div_state_t      state;
    div_state_t      state_n;
    logic [4:0]      cnt;
    logic [4:0]      rd_q;
    logic            rem_sel_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic            accept;
    logic            core_step;
    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] fix_res;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;

    assign is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    assign is_rem    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    assign a_neg     = is_signed && a[XLEN-1];
    assign b_neg     = is_signed && b[XLEN-1];
    assign a_mag     = neg_if(a, a_neg);
    assign b_mag     = neg_if(b, b_neg);

    // Divide-by-zero and signed overflow have architecturally fixed results
    // and skip the iteration entirely.
    assign div_zero  = (b == '0);
    assign overflow  = is_signed && (a == XLEN_MIN_NEG) && (b == ALL_ONES);
    assign special   = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? a : ALL_ONES;
        end else if (!is_rem) begin
            special_res = XLEN_MIN_NEG;
        end
    end

    assign fix_res = rem_sel_q ? neg_if(core_rem, r_neg_q) : neg_if(core_quo, q_neg_q);

    div_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (core_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        core_step = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept  = 1'b1;
                    state_n = special ? WB : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    core_step = 1'b1;
                    if (cnt == LAST_STEP) begin
                        state_n = FIX;
                    end
                end
            end
            FIX:     state_n = flush ? IDLE : WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Writeback registers are loaded on the edge entering WB so the pulse and
    // its address/data are stable for the whole WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            wb_we     <= 1'b0;
            wb_wa     <= '0;
            wb_wd     <= '0;
            cnt       <= '0;
            rd_q      <= '0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q      <= rd;
                        rem_sel_q <= is_rem;
                        q_neg_q   <= a_neg ^ b_neg;
                        r_neg_q   <= a_neg;
                        cnt       <= '0;
                        if (special) begin
                            wb_we <= (rd != 5'd0);
                            wb_wa <= rd;
                            wb_wd <= special_res;
                        end
                    end
                end
                CALC: cnt <= cnt + 5'd1;
                FIX: begin
                    if (!flush) begin
                        wb_we <= (rd_q != 5'd0);
                        wb_wa <= rd_q;
                        wb_wd <= fix_res;
                    end
                end
                WB:      wb_we <= 1'b0;
                default: wb_we <= 1'b0;
            endcase
        end
    end

endmodule
